ac_fan_actuator: RTL and testbench
==================================

// Module: ac_fan_actuator
// PURPOSE
//   Consumer side of the AC controller output interface. Takes fan_speed/fan_heat
//   commands and the measured room temperature, and drives the physical fan and compressor.
//   Fan: soft-ramped PWM drive. Compressor: on/off with hysteresis and restart lockout.
//   Sits between AC_control and the actuator pins.
// PARAMETERS
//   PWM_BITS     8   PWM counter/duty width; fixed at 8 in this revision
//   RAMP_DIV     16  clk cycles between duty ramp steps (>=1)
//   RAMP_STEP    16  duty change per ramp step (1..255)
//   MIN_OFF_CYC  64  compressor lockout cycles after switch-off (>=1)
//   HYST         1   compressor switch-off hysteresis, degrees (0..15)
// PORTS
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   fan_speed    in   3   commanded fan speed (0 = off, 4 = fastest)
//   fan_heat     in   8   commanded outlet temperature setpoint
//   temperature  in   7   measured room temperature
//   fan_pwm      out  1   registered fan PWM output
//   fan_duty     out  8   current ramped duty
//   comp_on      out  1   compressor enable
//   comp_state   out  2   00 OFF, 01 ON, 10 LOCKOUT
// BEHAVIOUR
//   Reset: all outputs 0; comp_state OFF; ramp, PWM and lockout counters 0.
//     Reset mid-ON returns to OFF with no lockout.
//   Target duty, decoded combinationally each cycle from fan_speed:
//     0->0, 1->64, 2->128, 3->192, 4..7->255.
//   Ramp:
//     - Divider counts 0..RAMP_DIV-1; on terminal count, fan_duty moves toward target by RAMP_STEP.
//     - Clamp to target; never overshoot; saturate within 0..255.
//     - fan_duty==target holds. A target change mid-ramp retargets on the next step.
//   PWM:
//     - Free-running 8-bit counter cnt; it wraps 255->0.
//     - duty_q latches fan_duty when cnt==255. Duty changes only at the period boundary, so no runt pulses.
//     - fan_pwm <= (cnt < duty_q). Duty 0 gives constant 0; duty 255 gives high 255 of 256 cycles.
//   Compressor validity:
//     - valid = (fan_heat < 128) && (fan_heat != 0).
//     - fan_heat >= 128 is an underflowed setpoint and is treated as no request.
//   Compressor FSM (9-bit zero-extended compares):
//     - OFF -> ON when fan_speed!=0 && valid && temperature > fan_heat.
//     - ON -> LOCKOUT when fan_speed==0 || !valid || temperature+HYST <= fan_heat.
//       Lockout counter loads MIN_OFF_CYC-1.
//     - LOCKOUT: counter decrements each cycle; at 0 -> OFF. Requests are ignored during LOCKOUT.
//     - comp_on = (state==ON), registered: it asserts the cycle after the entry condition is seen.
//   Simultaneous events: an entry condition arriving in the same cycle as lockout expiry is taken
//     from OFF on the following cycle. So the minimum restart gap is MIN_OFF_CYC+1 cycles.
// CONFIGURATION
//   AC_ACT_RUNTIME_EN defined:
//     - Adds output comp_runtime[15:0]: count of cycles with comp_on==1.
//     - Saturates at 16'hFFFF. Cleared only by reset.
//   Undefined: port and counter are absent. All other behaviour is identical.
// TESTING
//   1. Reset, fan_speed=4 -> fan_duty steps 16,32,.. every 16 clk; reaches 255 after 16 steps; never exceeds.
//   2. Duty 255 -> fan_speed=1 -> fan_duty ramps down to 64 exactly. fan_pwm high 64 of 256 cycles,
//      starting only after a cnt wrap.
//   3. speed=2, heat=22, temp 25 -> comp_on=1 next cycle. temp 23 -> stays on.
//      temp 21 (HYST=1) -> LOCKOUT, comp_on=0.
//   4. In LOCKOUT, temp 30 held -> comp_on stays 0 for 64 cycles, then OFF; comp_on=1 one cycle later.
//   5. heat=8'hFD (underflow), temp 25, speed 3 -> comp_on stays 0; fan_duty still ramps to 192.
//   6. Assert reset while ON at duty 128 -> all outputs 0 immediately (async); comp_state OFF;
//      with AC_ACT_RUNTIME_EN, comp_runtime=0.

Source files
------------

// File: rtl/ac_fan_actuator.sv
// ac_fan_actuator
//   Consumer side of the AC controller output interface. It drives the fan
//   with a soft-ramped PWM and switches the compressor on and off. The
//   compressor has switch-off hysteresis and a lockout period before it can
//   restart.
//
//   Optional feature: define AC_ACT_RUNTIME_EN to add the comp_runtime output.
//   That output is a saturating count of the cycles with comp_on high.
//
// Ports
//   clk          in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   fan_speed    in   3   commanded fan speed (0 = off, 4..7 = fastest)
//   fan_heat     in   8   commanded outlet temperature setpoint
//   temperature  in   7   measured room temperature
//   fan_pwm      out  1   registered fan PWM output
//   fan_duty     out  8   current ramped duty
//   comp_on      out  1   compressor enable (registered)
//   comp_state   out  2   00 OFF, 01 ON, 10 LOCKOUT
//   comp_runtime out  16  cycles with comp_on==1, saturating (AC_ACT_RUNTIME_EN only)
module ac_fan_actuator #(
  parameter int PWM_BITS    = 8,
  parameter int RAMP_DIV    = 16,
  parameter int RAMP_STEP   = 16,
  parameter int MIN_OFF_CYC = 64,
  parameter int HYST        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          fan_speed,
  input  logic [7:0]          fan_heat,
  input  logic [6:0]          temperature,
  output logic                fan_pwm,
  output logic [PWM_BITS-1:0] fan_duty,
  output logic                comp_on,
  output logic [1:0]          comp_state
`ifdef AC_ACT_RUNTIME_EN
  ,
  output logic [15:0]         comp_runtime
`endif
);

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int LOCK_W = (MIN_OFF_CYC > 1) ? $clog2(MIN_OFF_CYC) : 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_ON   = 2'b01,
    ST_LOCK = 2'b10
  } comp_st_t;

  logic [DIV_W-1:0]    div_r;
  logic [PWM_BITS-1:0] duty_r, duty_next_s, target_s;
  logic [PWM_BITS-1:0] cnt_r, duty_q_r;
  logic                pwm_r;
  comp_st_t            state_r, state_next_s;
  logic [LOCK_W-1:0]   lock_r, lock_next_s;
  logic                comp_on_r;
  logic                valid_s, entry_s, exit_s;
  logic [8:0]          duty9_s, tgt9_s;

  assign fan_duty   = duty_r;
  assign fan_pwm    = pwm_r;
  assign comp_on    = comp_on_r;
  assign comp_state = state_r;

  // Target duty decoded from the commanded speed.
  always_comb begin
    target_s = 8'd0;
    case (fan_speed)
      3'd0:    target_s = 8'd0;
      3'd1:    target_s = 8'd64;
      3'd2:    target_s = 8'd128;
      3'd3:    target_s = 8'd192;
      default: target_s = 8'd255;
    endcase
  end

  // One ramp step toward the target. The step clamps to the target, so it never overshoots.
  always_comb begin
    duty9_s     = {1'b0, duty_r};
    tgt9_s      = {1'b0, target_s};
    duty_next_s = duty_r;
    if (duty9_s < tgt9_s) begin
      if ((tgt9_s - duty9_s) > 9'(RAMP_STEP)) duty_next_s = 8'(duty9_s + 9'(RAMP_STEP));
      else                                    duty_next_s = target_s;
    end else if (duty9_s > tgt9_s) begin
      if ((duty9_s - tgt9_s) > 9'(RAMP_STEP)) duty_next_s = 8'(duty9_s - 9'(RAMP_STEP));
      else                                    duty_next_s = target_s;
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Ramp divider and ramped duty register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r  <= '0;
      duty_r <= 8'd0;
    end else if (div_r == DIV_W'(RAMP_DIV - 1)) begin
      div_r  <= '0;
      duty_r <= duty_next_s;
    end else begin
      div_r  <= div_r + DIV_W'(1);
    end
  end

  // PWM generator. The duty is sampled only at the period boundary, so no runt pulses occur.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= 8'd0;
      duty_q_r <= 8'd0;
      pwm_r    <= 1'b0;
    end else begin
      cnt_r <= cnt_r + 8'd1;
      pwm_r <= (cnt_r < duty_q_r);
      if (cnt_r == 8'd255) duty_q_r <= duty_r;
    end
  end

  // A setpoint of 128 or more is an underflowed value and does not request cooling.
  assign valid_s = (fan_heat < 8'd128) && (fan_heat != 8'd0);
  assign entry_s = (fan_speed != 3'd0) && valid_s &&
                   ({2'b00, temperature} > {1'b0, fan_heat});
  assign exit_s  = (fan_speed == 3'd0) || !valid_s ||
                   (({2'b00, temperature} + 9'(HYST)) <= {1'b0, fan_heat});

  // Compressor next-state logic and lockout countdown.
  always_comb begin
    state_next_s = state_r;
    lock_next_s  = lock_r;
    case (state_r)
      ST_OFF: begin
        if (entry_s) state_next_s = ST_ON;
        else         state_next_s = ST_OFF;
      end
      ST_ON: begin
        if (exit_s) begin
          state_next_s = ST_LOCK;
          lock_next_s  = LOCK_W'(MIN_OFF_CYC - 1);
        end else begin
          state_next_s = ST_ON;
        end
      end
      ST_LOCK: begin
        // Requests are ignored here. OFF re-evaluates them on the following cycle.
        if (lock_r == '0) state_next_s = ST_OFF;
        else              lock_next_s  = lock_r - LOCK_W'(1);
      end
      default: begin
        state_next_s = ST_OFF;
        lock_next_s  = '0;
      end
    endcase
  end

  // Compressor state, lockout counter and registered enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_OFF;
      lock_r    <= '0;
      comp_on_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      lock_r    <= lock_next_s;
      comp_on_r <= (state_next_s == ST_ON);
    end
  end

`ifdef AC_ACT_RUNTIME_EN
  logic [15:0] runtime_r;
  assign comp_runtime = runtime_r;

  // Saturating compressor run-time counter. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runtime_r <= 16'd0;
    end else if (comp_on_r && (runtime_r != 16'hFFFF)) begin
      runtime_r <= runtime_r + 16'd1;
    end else begin
      runtime_r <= runtime_r;
    end
  end
`else
`endif

endmodule

// File: tb/tb_ac_fan_actuator.sv
module tb_ac_fan_actuator;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fan_speed;
  logic [7:0] fan_heat;
  logic [6:0] temperature;
  logic       fan_pwm;
  logic [7:0] fan_duty;
  logic       comp_on;
  logic [1:0] comp_state;
`ifdef AC_ACT_RUNTIME_EN
  logic [15:0] comp_runtime;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ac_fan_actuator dut (
    .clk         (clk),
    .reset       (reset),
    .fan_speed   (fan_speed),
    .fan_heat    (fan_heat),
    .temperature (temperature),
    .fan_pwm     (fan_pwm),
    .fan_duty    (fan_duty),
    .comp_on     (comp_on),
    .comp_state  (comp_state)
`ifdef AC_ACT_RUNTIME_EN
    ,
    .comp_runtime(comp_runtime)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int highs;
    int on_seen;
    reset = 1'b1; fan_speed = 3'd0; fan_heat = 8'd0; temperature = 7'd0;
    step(2);
    check("rst_duty", fan_duty, 8'd0);
    check("rst_pwm", fan_pwm, 1'b0);
    check("rst_comp_on", comp_on, 1'b0);
    check("rst_state", comp_state, 2'b00);

    // 1: ramp up to full speed, 16 per 16 clocks, clamped at 255.
    reset = 1'b0; fan_speed = 3'd4;
    step(15);
    check("ramp_pre_first", fan_duty, 8'd0);
    step(1);
    check("ramp_step1", fan_duty, 8'd16);
    for (int k = 2; k <= 16; k++) begin
      step(16);
      check($sformatf("ramp_up_%0d", k), fan_duty, (k == 16) ? 32'd255 : 32'(16 * k));
    end
    step(16);
    check("ramp_hold_255", fan_duty, 8'd255);

    // 2: ramp down to 64. The 11th step gives 79, and the 12th step clamps to 64.
    fan_speed = 3'd1;
    step(16 * 11);
    check("ramp_down_11", fan_duty, 8'd79);
    step(16);
    check("ramp_down_64", fan_duty, 8'd64);
    step(256);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (fan_pwm) highs++;
    end
    check("pwm_highs_64", highs, 64);

    // 3: compressor on and hysteresis.
    fan_speed = 3'd2; fan_heat = 8'd22; temperature = 7'd25;
    check("comp_before_edge", comp_on, 1'b0);
    step(1);
    check("comp_on_next", comp_on, 1'b1);
    check("state_on", comp_state, 2'b01);
    temperature = 7'd23; step(1);
    check("comp_hold_23", comp_on, 1'b1);
    temperature = 7'd22; step(1);
    check("comp_hold_22", comp_on, 1'b1);
    temperature = 7'd21; step(1);
    check("comp_off_21", comp_on, 1'b0);
    check("state_lock", comp_state, 2'b10);

    // 4: lockout ignores requests for MIN_OFF_CYC cycles.
    temperature = 7'd30;
    on_seen = 0;
    for (int i = 0; i < 63; i++) begin
      step(1);
      if (comp_on) on_seen++;
    end
    check("lock_no_on", on_seen, 0);
    check("lock_still", comp_state, 2'b10);
    step(1);
    check("lock_to_off", comp_state, 2'b00);
    check("lock_off_comp", comp_on, 1'b0);
    step(1);
    check("restart_on", comp_on, 1'b1);

    // 5: an underflowed setpoint gives no request, and the fan still ramps.
    fan_heat = 8'hFD; temperature = 7'd25; fan_speed = 3'd3;
    step(1);
    check("underflow_exit", comp_state, 2'b10);
    on_seen = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (comp_on) on_seen++;
    end
    check("underflow_no_on", on_seen, 0);
    check("underflow_off", comp_state, 2'b00);
    check("duty_192", fan_duty, 8'd192);
    fan_heat = 8'd128; temperature = 7'd127;
    step(5);
    check("heat128_no_on", comp_on, 1'b0);
    fan_heat = 8'd0; temperature = 7'd25;
    step(5);
    check("heat0_no_on", comp_on, 1'b0);

    // 6: async reset while ON at duty 128. No lockout follows.
    fan_speed = 3'd2; fan_heat = 8'd22; temperature = 7'd25;
    step(100);
    check("pre_rst_on", comp_on, 1'b1);
    check("pre_rst_duty", fan_duty, 8'd128);
    #2 reset = 1'b1;
    #1;
    check("async_duty", fan_duty, 8'd0);
    check("async_pwm", fan_pwm, 1'b0);
    check("async_comp", comp_on, 1'b0);
    check("async_state", comp_state, 2'b00);
`ifdef AC_ACT_RUNTIME_EN
    check("async_runtime", comp_runtime, 16'd0);
`endif
    step(1);
    reset = 1'b0;
    step(1);
    check("post_rst_no_lock", comp_on, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
